life_engine_grid: RTL and testbench

- Parametrised Conway Game-of-Life engine; successor to the single-cycle simulation block.
- Holds a GRID_W x GRID_H one-bit cell grid in row-wide memory.
- Computes one generation per start pulse with a row-serial scan using three line registers.
- Emits one pixel-write per changed cell to the 160x120 vga_adapter plot port (x, y, colour, plot).
- Also accepts single-cell load/erase writes from the user-input front end.

---
 rtl/life_engine_grid.sv | 238 +++++++++++++++++++++++
 tb/tb_life_engine_grid.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine_grid.sv
// life_engine_grid
//   Conway Game-of-Life engine. The cell grid is kept one row per memory
//   word. Each start pulse computes one generation with a row-serial scan
//   over three line registers (prev/cur/nxt). Every cell that changes state
//   produces one pixel write on the vga_adapter plot port. Single-cell loads
//   and erases from the user-input front end also produce one pixel write.
//
// Ports
//   clock       system clock
//   reset_n     synchronous, active-low reset
//   load        single-cycle cell write request (honoured only in IDLE)
//   load_val    value written by load (1 = alive, 0 = dead)
//   x_in, y_in  cell coordinates for load
//   start       single-cycle request to compute one generation (IDLE only)
//   busy        high while clearing or computing a generation
//   done        one-cycle pulse when a generation completes
//   out_x/out_y plot coordinates
//   colour      plot colour
//   plot        one-cycle pixel-write strobe
//   generation  completed-generation count (wraps)
//
// Build option
//   LIFE_WRAP_EN  when defined the grid is toroidal. Neighbour columns wrap,
//                 and the first and last rows are neighbours. The original
//                 row 0 is saved during PRIME because it has already been
//                 overwritten by the time the last row needs it.
`timescale 1ns/1ps
module life_engine_grid #(
   parameter int         GRID_W       = 160,
   parameter int         GRID_H       = 120,
   parameter int         X_W          = 8,
   parameter int         Y_W          = 7,
   parameter logic [2:0] ALIVE_COLOUR = 3'b111,
   parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic           load,
   input  logic           load_val,
   input  logic [X_W-1:0] x_in,
   input  logic [Y_W-1:0] y_in,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic [2:0]     colour,
   output logic           plot,
   output logic [15:0]    generation
);

   localparam logic [X_W-1:0] LAST_COL = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] LAST_ROW = Y_W'(GRID_H - 1);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_PRIME,
      S_SCAN,
      S_ADV,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   logic [GRID_W-1:0] mem_q [GRID_H];
   logic [GRID_W-1:0] prev_q, cur_q, nxt_q, new_q;
`ifdef LIFE_WRAP_EN
   logic [GRID_W-1:0] saved_q;
`endif

   logic [Y_W-1:0] r_q;
   logic [X_W-1:0] c_q;
   logic           prime_ph_q;

   logic           plot_q, done_q;
   logic [X_W-1:0] out_x_q;
   logic [Y_W-1:0] out_y_q;
   logic [2:0]     colour_q;
   logic [15:0]    gen_q;

   // Bit of a row at a column; columns outside the grid read as dead.
   function automatic logic cell_at(input logic [GRID_W-1:0] row, input int col);
      logic [GRID_W-1:0] sh;
      logic              bit_v;
      sh    = '0;
      bit_v = 1'b0;
      if (col >= 0 && col < GRID_W) begin
         sh    = row >> col;
         bit_v = sh[0];
      end
      return bit_v;
   endfunction

   // Neighbour count and successor value for the column being scanned
   int       col_l, col_r;
   logic [3:0] n_w;
   logic       cur_bit_w, new_w;

   always_comb begin
      col_l = int'(c_q) - 1;
      col_r = int'(c_q) + 1;
`ifdef LIFE_WRAP_EN
      if (col_l < 0)       col_l = GRID_W - 1;
      if (col_r >= GRID_W) col_r = 0;
`endif
      n_w = 4'(cell_at(prev_q, col_l)) + 4'(cell_at(prev_q, int'(c_q))) + 4'(cell_at(prev_q, col_r))
          + 4'(cell_at(cur_q,  col_l))                                  + 4'(cell_at(cur_q,  col_r))
          + 4'(cell_at(nxt_q,  col_l)) + 4'(cell_at(nxt_q,  int'(c_q))) + 4'(cell_at(nxt_q,  col_r));
      cur_bit_w = cell_at(cur_q, int'(c_q));
      new_w     = (n_w == 4'd3) | (cur_bit_w & (n_w == 4'd2));
   end

   // Row two below the current one. It feeds nxt when advancing. Past the bottom edge
   // it is dead, or the saved original row 0 on a torus.
   logic [GRID_W-1:0] nxt_fetch_w;
   logic [Y_W-1:0]    r_plus2_w;

   always_comb begin
      r_plus2_w   = '0;
      nxt_fetch_w = '0;
      if (int'(r_q) + 2 < GRID_H) begin
         r_plus2_w   = r_q + Y_W'(2);
         nxt_fetch_w = mem_q[r_plus2_w];
      end
`ifdef LIFE_WRAP_EN
      else if (int'(r_q) + 2 == GRID_H) begin
         nxt_fetch_w = saved_q;
      end
`endif
   end

   logic load_ok_w;
   assign load_ok_w = load && (int'(x_in) < GRID_W) && (int'(y_in) < GRID_H);

   // State register
   always_ff @(posedge clock) begin
      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (r_q == LAST_ROW) state_d = S_IDLE;
         S_IDLE:  if (!load && start) state_d = S_PRIME;
         S_PRIME: if (prime_ph_q) state_d = S_SCAN;
         S_SCAN:  if (c_q == LAST_COL) state_d = S_ADV;
         S_ADV:   state_d = (r_q == LAST_ROW) ? S_FIN : S_SCAN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_CLEAR;
      endcase
      if (!reset_n) state_d = S_CLEAR;
   end

   // Counters, grid memory, line registers and plot port
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_q        <= '0;
         c_q        <= '0;
         prime_ph_q <= 1'b0;
         plot_q     <= 1'b0;
         done_q     <= 1'b0;
         out_x_q    <= '0;
         out_y_q    <= '0;
         colour_q   <= DEAD_COLOUR;
         gen_q      <= '0;
      end else begin
         plot_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               mem_q[r_q] <= '0;
               r_q        <= (r_q == LAST_ROW) ? '0 : r_q + Y_W'(1);
            end
            S_IDLE: begin
               if (load_ok_w) begin
                  mem_q[y_in][x_in] <= load_val;
                  plot_q            <= 1'b1;
                  out_x_q           <= x_in;
                  out_y_q           <= y_in;
                  colour_q          <= load_val ? ALIVE_COLOUR : DEAD_COLOUR;
               end else if (!load && start) begin
                  r_q        <= '0;
                  c_q        <= '0;
                  prime_ph_q <= 1'b0;
               end
            end
            S_PRIME: begin
               if (!prime_ph_q) begin
                  cur_q <= mem_q[0];
`ifdef LIFE_WRAP_EN
                  prev_q  <= mem_q[GRID_H-1];
                  saved_q <= mem_q[0];
`else
                  prev_q <= '0;
`endif
               end else begin
                  nxt_q <= mem_q[1];
               end
               prime_ph_q <= ~prime_ph_q;
            end
            S_SCAN: begin
               new_q[c_q] <= new_w;
               if (new_w != cur_bit_w) begin
                  plot_q   <= 1'b1;
                  out_x_q  <= c_q;
                  out_y_q  <= r_q;
                  colour_q <= new_w ? ALIVE_COLOUR : DEAD_COLOUR;
               end
               c_q <= (c_q == LAST_COL) ? '0 : c_q + X_W'(1);
            end
            S_ADV: begin
               // The old cur row becomes prev, so the next row sees pre-update values.
               mem_q[r_q] <= new_q;
               prev_q     <= cur_q;
               cur_q      <= nxt_q;
               nxt_q      <= nxt_fetch_w;
               r_q        <= (r_q == LAST_ROW) ? '0 : r_q + Y_W'(1);
            end
            S_FIN: begin
               done_q <= 1'b1;
               gen_q  <= gen_q + 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy       = !reset_n || (state_q != S_IDLE);
   assign done       = done_q;
   assign plot       = plot_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign colour     = colour_q;
   assign generation = gen_q;

endmodule

// File: tb/tb_life_engine_grid.sv
`timescale 1ns/1ps
module tb_life_engine_grid;

   localparam int GW  = 160;
   localparam int GH  = 120;
   localparam int LAT = 2 + GH * (GW + 1) + 1;

   logic        clock = 1'b0;
   logic        reset_n, load, load_val, start;
   logic [7:0]  x_in;
   logic [6:0]  y_in;
   logic        busy, done, plot;
   logic [7:0]  out_x;
   logic [6:0]  out_y;
   logic [2:0]  colour;
   logic [15:0] generation;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } plot_t;

   plot_t plots[$];
   int    done_cnt = 0;

   life_engine_grid dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (load),
      .load_val   (load_val),
      .x_in       (x_in),
      .y_in       (y_in),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .out_x      (out_x),
      .out_y      (out_y),
      .colour     (colour),
      .plot       (plot),
      .generation (generation)
   );

   always #5 clock = ~clock;

   // Record every pixel write and done pulse
   always @(negedge clock) begin
      if (plot === 1'b1) plots.push_back(plot_t'({out_x, out_y, colour}));
      if (done === 1'b1) done_cnt++;
   end

   function automatic plot_t mk(input int x, input int y, input logic [2:0] c);
      return plot_t'({8'(x), 7'(y), c});
   endfunction

   task automatic load_cell(input int x, input int y, input logic v);
      @(negedge clock);
      load = 1'b1; load_val = v; x_in = 8'(x); y_in = 7'(y);
      @(negedge clock);
      load = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clock);
      #1;
   endtask

   // Pulse start and count edges after the sampling edge until done.
   // At cycle inject_at, a load and a start are driven while the engine is busy.
   task automatic run_gen(input int inject_at, output int lat);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      while (lat < 25000) begin
         @(posedge clock); #1;
         lat++;
         if (inject_at > 0 && lat == inject_at) begin
            start = 1'b1; load = 1'b1; load_val = 1'b1; x_in = 8'd100; y_in = 7'd100;
         end else begin
            start = 1'b0; load = 1'b0;
         end
         if (done === 1'b1) break;
      end
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         cnt++;
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset();
      int base, cnt;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_checks++; if ({plot, done} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: plot/done got %b want 00", {plot, done}); end
      n_checks++; if (generation !== 16'd0) begin n_fail++; $display("FAIL reset_generation: got %0d want 0", generation); end
      n_checks++; if ({out_x, out_y, colour} !== 18'd0) begin n_fail++; $display("FAIL reset_plot_port: got x=%0d y=%0d c=%0d want 0 0 0", out_x, out_y, colour); end
      base = plots.size();
      @(negedge clock);
      reset_n = 1'b1;
      wait_idle(cnt);
      n_checks++; if (cnt !== GH) begin n_fail++; $display("FAIL clear_length: busy cycles got %0d want %0d", cnt, GH); end
      n_checks++; if (plots.size() - base !== 0) begin n_fail++; $display("FAIL clear_no_plot: got %0d plots want 0", plots.size() - base); end
      n_checks++; if (generation !== 16'd0) begin n_fail++; $display("FAIL clear_generation: got %0d want 0", generation); end
   endtask

   task automatic test_mid_scan_reset();
      int base, base2, dbase, lat, cnt;
      base = plots.size();
      load_cell(80, 60, 1'b1);
      load_cell(81, 60, 1'b1);
      load_cell(82, 60, 1'b1);
      settle();
      n_checks++; if (plots.size() - base !== 3) begin n_fail++; $display("FAIL midrst_load_plots: got %0d want 3", plots.size() - base); end
      base = plots.size();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      while (lat < 2 + 60 * (GW + 1) + 5) begin
         @(posedge clock); #1;
         lat++;
      end
      n_checks++;
      if (plots.size() - base !== 1) begin
         n_fail++; $display("FAIL midrst_row59_plots: got %0d want 1", plots.size() - base);
      end else if (plots[base] !== mk(81, 59, 3'b111)) begin
         n_fail++; $display("FAIL midrst_row59_plot: got x=%0d y=%0d c=%0d want x=81 y=59 c=7", plots[base].x, plots[base].y, plots[base].c);
      end
      reset_n = 1'b0;
      base2 = plots.size();
      dbase = done_cnt;
      @(posedge clock); #1;
      n_checks++; if ({plot, busy} !== 2'b01) begin n_fail++; $display("FAIL midrst_abort: plot/busy got %b want 01", {plot, busy}); end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      wait_idle(cnt);
      n_checks++; if (cnt !== GH) begin n_fail++; $display("FAIL midrst_clear_length: got %0d want %0d", cnt, GH); end
      n_checks++; if (plots.size() - base2 !== 0) begin n_fail++; $display("FAIL midrst_no_plot: got %0d plots want 0", plots.size() - base2); end
      n_checks++; if (done_cnt - dbase !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - dbase); end
      n_checks++; if (generation !== 16'd0) begin n_fail++; $display("FAIL midrst_generation: got %0d want 0", generation); end
   endtask

   task automatic test_load();
      @(negedge clock);
      load = 1'b1; load_val = 1'b1; x_in = 8'd200; y_in = 7'd5;
      @(negedge clock);
      load = 1'b0;
      n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL load_x_range: plot got %b want 0", plot); end
      @(negedge clock);
      load = 1'b1; load_val = 1'b1; x_in = 8'd5; y_in = 7'd125;
      @(negedge clock);
      load = 1'b0;
      n_checks++; if (plot !== 1'b0) begin n_fail++; $display("FAIL load_y_range: plot got %b want 0", plot); end
      @(negedge clock);
      load = 1'b1; start = 1'b1; load_val = 1'b1; x_in = 8'd20; y_in = 7'd20;
      @(negedge clock);
      load = 1'b0; start = 1'b0;
      n_checks++;
      if ({plot, out_x, out_y, colour} !== {1'b1, 8'd20, 7'd20, 3'b111}) begin
         n_fail++; $display("FAIL load_alive: got p=%b x=%0d y=%0d c=%0d want p=1 x=20 y=20 c=7", plot, out_x, out_y, colour);
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_priority: busy got %b want 0", busy); end
      @(negedge clock);
      n_checks++; if ({plot, busy} !== 2'b00) begin n_fail++; $display("FAIL load_strobe_len: plot/busy got %b want 00", {plot, busy}); end
      load_cell(20, 20, 1'b0);
      n_checks++;
      if ({plot, out_x, out_y, colour} !== {1'b1, 8'd20, 7'd20, 3'b000}) begin
         n_fail++; $display("FAIL load_dead: got p=%b x=%0d y=%0d c=%0d want p=1 x=20 y=20 c=0", plot, out_x, out_y, colour);
      end
   endtask

   task automatic test_blinker_block();
      plot_t exp [4];
      int base, dbase, lat;
      load_cell(10, 10, 1'b1);
      load_cell(11, 10, 1'b1);
      load_cell(12, 10, 1'b1);
      load_cell(50, 50, 1'b1);
      load_cell(51, 50, 1'b1);
      load_cell(50, 51, 1'b1);
      load_cell(51, 51, 1'b1);
      settle();
      base  = plots.size();
      dbase = done_cnt;
      run_gen(700, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL gen1_latency: got %0d want %0d", lat, LAT); end
      exp[0] = mk(11, 9, 3'b111);
      exp[1] = mk(10, 10, 3'b000);
      exp[2] = mk(12, 10, 3'b000);
      exp[3] = mk(11, 11, 3'b111);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (base + i >= plots.size()) begin
            n_fail++; $display("FAIL gen1_plot%0d: missing, want x=%0d y=%0d c=%0d", i, exp[i].x, exp[i].y, exp[i].c);
         end else if (plots[base+i] !== exp[i]) begin
            n_fail++; $display("FAIL gen1_plot%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                               plots[base+i].x, plots[base+i].y, plots[base+i].c, exp[i].x, exp[i].y, exp[i].c);
         end
      end
      n_checks++; if (generation !== 16'd1) begin n_fail++; $display("FAIL gen1_count: got %0d want 1", generation); end
      repeat (5) @(posedge clock);
      #1;
      n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL gen1_done_pulses: got %0d want 1", done_cnt - dbase); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL gen1_start_ignored: busy got %b want 0", busy); end
      n_checks++; if (plots.size() - base !== 4) begin n_fail++; $display("FAIL gen1_plot_total: got %0d want 4", plots.size() - base); end

      base = plots.size();
      run_gen(0, lat);
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL gen2_latency: got %0d want %0d", lat, LAT); end
      exp[0] = mk(11, 9, 3'b000);
      exp[1] = mk(10, 10, 3'b111);
      exp[2] = mk(12, 10, 3'b111);
      exp[3] = mk(11, 11, 3'b000);
      settle();
      n_checks++; if (plots.size() - base !== 4) begin n_fail++; $display("FAIL gen2_plot_total: got %0d want 4", plots.size() - base); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (base + i >= plots.size()) begin
            n_fail++; $display("FAIL gen2_plot%0d: missing, want x=%0d y=%0d c=%0d", i, exp[i].x, exp[i].y, exp[i].c);
         end else if (plots[base+i] !== exp[i]) begin
            n_fail++; $display("FAIL gen2_plot%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                               plots[base+i].x, plots[base+i].y, plots[base+i].c, exp[i].x, exp[i].y, exp[i].c);
         end
      end
      n_checks++; if (generation !== 16'd2) begin n_fail++; $display("FAIL gen2_count: got %0d want 2", generation); end
   endtask

   task automatic test_edge_blinker();
      plot_t exp [4];
      int ne, base, lat, cnt;
      @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      wait_idle(cnt);
      n_checks++; if (generation !== 16'd0) begin n_fail++; $display("FAIL edge_reset_count: got %0d want 0", generation); end
      load_cell(0, 5, 1'b1);
      load_cell(0, 6, 1'b1);
      load_cell(0, 7, 1'b1);
      settle();
      base = plots.size();
      run_gen(0, lat);
      settle();
      exp[0] = mk(0, 5, 3'b000);
      exp[1] = mk(1, 6, 3'b111);
`ifdef LIFE_WRAP_EN
      exp[2] = mk(159, 6, 3'b111);
      exp[3] = mk(0, 7, 3'b000);
      ne = 4;
`else
      exp[2] = mk(0, 7, 3'b000);
      exp[3] = mk(0, 0, 3'b000);
      ne = 3;
`endif
      n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL edge_latency: got %0d want %0d", lat, LAT); end
      n_checks++; if (plots.size() - base !== ne) begin n_fail++; $display("FAIL edge_plot_total: got %0d want %0d", plots.size() - base, ne); end
      for (int i = 0; i < ne; i++) begin
         n_checks++;
         if (base + i >= plots.size()) begin
            n_fail++; $display("FAIL edge_plot%0d: missing, want x=%0d y=%0d c=%0d", i, exp[i].x, exp[i].y, exp[i].c);
         end else if (plots[base+i] !== exp[i]) begin
            n_fail++; $display("FAIL edge_plot%0d: got x=%0d y=%0d c=%0d want x=%0d y=%0d c=%0d", i,
                               plots[base+i].x, plots[base+i].y, plots[base+i].c, exp[i].x, exp[i].y, exp[i].c);
         end
      end
      n_checks++; if (generation !== 16'd1) begin n_fail++; $display("FAIL edge_count: got %0d want 1", generation); end
   endtask

   initial begin
      reset_n  = 1'b0;
      load     = 1'b0;
      load_val = 1'b0;
      start    = 1'b0;
      x_in     = '0;
      y_in     = '0;
      test_reset();
      test_mid_scan_reset();
      test_load();
      test_blinker_block();
      test_edge_blinker();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
